din_debounce: RTL and testbench

Per-bit debounce and change-event stage that consumes the 3-bit registered output of the front-end D flip-flop stage. Each bit is filtered with a stability counter. A change in the filtered value is reported as a buffered valid/ready event carrying a change mask, the new value and an overrun flag. The block sits between the capture flop and downstream control logic, which consumes events at its own pace.

---
 rtl/din_debounce_pkg.sv | 20 ++
 rtl/din_deb_bit.sv | 44 ++++
 rtl/din_debounce.sv | 92 +++++++++
 tb/tb_din_debounce.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/din_debounce_pkg.sv
// Shared constants and types for the din debounce block: default sizes, bit vector and event record.
package din_debounce_pkg;

  localparam int DEB_WIDTH  = 3;
  localparam int DEB_STABLE = 4;

  typedef logic [DEB_WIDTH-1:0] deb_vec_t;

  typedef struct packed {
    deb_vec_t mask;
    deb_vec_t value;
    logic     ovf;
  } deb_evt_t;

  // Counter needs to hold 0..stable-1; keep at least one bit for the smallest legal window.
  function automatic int deb_cnt_w(input int stable);
    return (stable <= 2) ? 1 : $clog2(stable);
  endfunction

endpackage

// File: rtl/din_deb_bit.sv
// One-bit stability filter: counts consecutive disagreeing samples and toggles its output on the last one.
// o_flip is combinational and high on the edge where the output is about to toggle.
module din_deb_bit
  import din_debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEB_STABLE,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_dout,
  output logic o_flip
);

  localparam int            CW       = deb_cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_dout;
  logic          w_diff;

  assign w_diff = i_din ^ r_dout;
  assign o_flip = w_diff && (r_cnt == CNT_LAST);
  assign o_dout = r_dout;

  // The count saturates at CNT_LAST by construction: reaching it either toggles or clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_dout <= RESET_VAL;
    end else begin
      if (!w_diff || o_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (o_flip) begin
        r_dout <= ~r_dout;
      end
    end
  end

endmodule

// File: rtl/din_debounce.sv
// Per-bit debounce with a one-entry change-event buffer (valid/ready); all event outputs registered.
// Optional 2-flop input synchronizer when DIN_DEBOUNCE_SYNC_EN is defined.
module din_debounce
  import din_debounce_pkg::*;
#(
  parameter int               WIDTH         = DEB_WIDTH,
  parameter int               STABLE_CYCLES = DEB_STABLE,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             chg_valid,
  input  logic             chg_ready,
  output logic [WIDTH-1:0] chg_mask,
  output logic [WIDTH-1:0] chg_value,
  output logic             chg_ovf
);

  logic [WIDTH-1:0] w_din;
  logic [WIDTH-1:0] w_dout;
  logic [WIDTH-1:0] w_flip;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_accept;
  deb_evt_t         r_evt;
  logic             r_vld;

`ifdef DIN_DEBOUNCE_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_din = r_sync2;
`else
  assign w_din = din;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    din_deb_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_VAL     (RESET_VAL[i])
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_din  (w_din[i]),
      .o_dout (w_dout[i]),
      .o_flip (w_flip[i])
    );
  end

  assign w_dout_nxt = w_dout ^ w_flip;
  assign w_accept   = r_vld && chg_ready;

  // An accept on the same edge as a new flip starts a fresh event rather than folding into the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld       <= 1'b0;
      r_evt.mask  <= '0;
      r_evt.value <= RESET_VAL;
      r_evt.ovf   <= 1'b0;
    end else if (|w_flip) begin
      r_vld       <= 1'b1;
      r_evt.value <= w_dout_nxt;
      if (!r_vld || w_accept) begin
        r_evt.mask <= w_flip;
        r_evt.ovf  <= 1'b0;
      end else begin
        r_evt.mask <= r_evt.mask | w_flip;
        r_evt.ovf  <= 1'b1;
      end
    end else if (w_accept) begin
      r_vld <= 1'b0;
    end
  end

  assign dout      = w_dout;
  assign chg_valid = r_vld;
  assign chg_mask  = r_evt.mask;
  assign chg_value = r_evt.value;
  assign chg_ovf   = r_evt.ovf;

endmodule

// File: tb/tb_din_debounce.sv
// Bench for din_debounce: directed scenarios with literal expectations plus randomized traffic against a run-length model.
module tb_din_debounce;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] din = 3'b111;
  logic       chg_ready = 1'b0;
  logic [2:0] dout;
  logic       chg_valid;
  logic [2:0] chg_mask;
  logic [2:0] chg_value;
  logic       chg_ovf;

  int errors = 0;
  int checks = 0;
  bit en_cmp = 1'b0;

  din_debounce dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .dout      (dout),
    .chg_valid (chg_valid),
    .chg_ready (chg_ready),
    .chg_mask  (chg_mask),
    .chg_value (chg_value),
    .chg_ovf   (chg_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: each bit tracks how long the input has disagreed with its output.
  int         m_run [3];
  logic [2:0] m_dout;
  logic       m_vld;
  logic [2:0] m_mask;
  logic [2:0] m_value;
  logic       m_ovf;

  always @(posedge clk or negedge rst_n) begin
    logic [2:0] flip;
    logic [2:0] nd;
    logic       acc;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_run[i] <= 0;
      m_dout  <= 3'b000;
      m_vld   <= 1'b0;
      m_mask  <= 3'b000;
      m_value <= 3'b000;
      m_ovf   <= 1'b0;
    end else begin
      flip = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (din[i] == m_dout[i]) begin
          m_run[i] <= 0;
        end else if (m_run[i] + 1 >= STABLE) begin
          flip[i] = 1'b1;
          m_run[i] <= 0;
        end else begin
          m_run[i] <= m_run[i] + 1;
        end
      end
      nd  = m_dout ^ flip;
      acc = m_vld && chg_ready;
      m_dout <= nd;
      if (flip != 3'b000) begin
        m_vld   <= 1'b1;
        m_value <= nd;
        if (!m_vld || acc) begin
          m_mask <= flip;
          m_ovf  <= 1'b0;
        end else begin
          m_mask <= m_mask | flip;
          m_ovf  <= 1'b1;
        end
      end else if (acc) begin
        m_vld <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      chk("cyc_dout",  dout,      m_dout);
      chk("cyc_valid", chg_valid, m_vld);
      chk("cyc_mask",  chg_mask,  m_mask);
      chk("cyc_value", chg_value, m_value);
      chk("cyc_ovf",   chg_ovf,   m_ovf);
    end
  end

  initial begin
    tick(2);
    chk("rst_dout",  dout,      3'b000);
    chk("rst_valid", chg_valid, 1'b0);
    chk("rst_mask",  chg_mask,  3'b000);
    chk("rst_value", chg_value, 3'b000);
    chk("rst_ovf",   chg_ovf,   1'b0);
    rst_n  = 1'b1;
    en_cmp = 1'b1;

    tick(3);
    chk("win3_dout",  dout,      3'b000);
    chk("win3_valid", chg_valid, 1'b0);
    tick(1);
    chk("win4_dout",  dout,      3'b111);
    chk("win4_valid", chg_valid, 1'b1);
    chk("win4_mask",  chg_mask,  3'b111);
    chk("win4_value", chg_value, 3'b111);
    chk("win4_ovf",   chg_ovf,   1'b0);
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    chk("acc1_valid", chg_valid, 1'b0);

    din = 3'b000;
    tick(4);
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      din = 3'b001;
      tick(3);
      din = 3'b000;
      tick(1);
    end
    chk("glitch_dout",  dout,      3'b000);
    chk("glitch_valid", chg_valid, 1'b0);

    din = 3'b010;
    tick(4);
    din = 3'b110;
    tick(4);
    chk("fold_valid", chg_valid, 1'b1);
    chk("fold_mask",  chg_mask,  3'b110);
    chk("fold_value", chg_value, 3'b110);
    chk("fold_ovf",   chg_ovf,   1'b1);
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    chk("fold_acc_valid", chg_valid, 1'b0);

    din = 3'b111;
    tick(4);
    din = 3'b011;
    tick(3);
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    chk("reload_valid", chg_valid, 1'b1);
    chk("reload_mask",  chg_mask,  3'b100);
    chk("reload_value", chg_value, 3'b011);
    chk("reload_ovf",   chg_ovf,   1'b0);
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;

    din = 3'b000;
    tick(4);
    din = 3'b111;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dout",  dout,      3'b000);
    chk("arst_valid", chg_valid, 1'b0);
    chk("arst_mask",  chg_mask,  3'b000);
    chk("arst_value", chg_value, 3'b000);
    chk("arst_ovf",   chg_ovf,   1'b0);
    din = 3'b101;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("post_dout",  dout,      3'b000);
    chk("post_valid", chg_valid, 1'b0);
    tick(1);
    chk("post4_dout",  dout,      3'b101);
    chk("post4_valid", chg_valid, 1'b1);
    chk("post4_mask",  chg_mask,  3'b101);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) din = 3'($urandom_range(0, 7));
      chg_ready = ($urandom_range(0, 2) == 0);
      tick(1);
    end

    en_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
